// File: rtl/multi_pwm_pkg.sv
// ============================================================================
//  multi_pwm_pkg : shared constants, helpers and types for multi_pwm_dbuf
//  Revision      : 1.0
// ============================================================================
`default_nettype none

package multi_pwm_pkg;

    localparam int NCH_DEFAULT   = 24;
    localparam int WIDTH_DEFAULT = 10;

    // A single channel still needs a 1-bit index port.
    function automatic int ch_idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    typedef logic [WIDTH_DEFAULT-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/pwm_chan_cmp.sv
// ============================================================================
//  pwm_chan_cmp : one PWM channel - active duty/phase, wrapped compare, out reg
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module pwm_chan_cmp
    import multi_pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] ton_s_i,
    input  logic [WIDTH-1:0] phase_s_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic             oe_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] ton_a_q;
    logic [WIDTH-1:0] phase_a_q;
    logic             pwm_q;

    logic [WIDTH-1:0] w_ph;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_dist;
    logic             w_raw;

    // Distance from the phase point, folded back into 0..period-1.
    always_comb begin
        w_ph   = (phase_a_q < period_i) ? phase_a_q : '0;
        w_diff = {1'b0, cnt_i} - {1'b0, w_ph};
        w_dist = w_diff[WIDTH] ? (w_diff + {1'b0, period_i}) : w_diff;
        w_raw  = (period_i != '0) && (w_dist < {1'b0, ton_a_q});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ton_a_q   <= '0;
            phase_a_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (load_i) begin
                ton_a_q   <= ton_s_i;
                phase_a_q <= phase_s_i;
            end
            pwm_q <= w_raw & oe_i;
        end
    end

    assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/multi_pwm_dbuf.sv
// ============================================================================
//  multi_pwm_dbuf : multi-channel PWM with shadow/active registers that swap
//                   only on a period boundary
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module multi_pwm_dbuf
    import multi_pwm_pkg::*;
#(
    parameter int NCH   = NCH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [ch_idx_width(NCH)-1:0]   wr_ch,
    input  logic [WIDTH-1:0]               wr_ton,
    input  logic [WIDTH-1:0]               wr_phase,
    input  logic                           period_wr,
    input  logic [WIDTH-1:0]               period_in,
    input  logic                           commit,
    input  logic [NCH-1:0]                 oe,
    output logic [NCH-1:0]                 pwm_out,
    output logic                           period_start,
    output logic                           update_pending,
    output logic                           update_done
);

    localparam int CHW = ch_idx_width(NCH);

    logic [WIDTH-1:0] period_a_q;
    logic [WIDTH-1:0] period_s_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             pending_q;
    logic             pending_d;
    logic             period_start_q;
    logic             update_done_q;

    logic             w_running;
    logic             w_boundary;
    logic             w_xfer;

    // When stopped there is no boundary to wait for, so a pending transfer
    // goes through on the very next cycle.
    always_comb begin
        w_running  = (period_a_q != '0);
        w_boundary = w_running && (cnt_q == (period_a_q - WIDTH'(1)));
        w_xfer     = pending_q && (w_boundary || !w_running);

        pending_d  = w_xfer ? 1'b0 : (pending_q | commit);

        if (w_xfer || w_boundary || !w_running) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_a_q     <= '0;
            period_s_q     <= '0;
            cnt_q          <= '0;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
            update_done_q  <= 1'b0;
        end else begin
            if (w_xfer) begin
                period_a_q <= period_s_q;
            end
            if (period_wr) begin
                period_s_q <= period_in;
            end
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            period_start_q <= w_running && (cnt_q == '0);
            update_done_q  <= w_xfer;
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            logic [WIDTH-1:0] ton_s_q;
            logic [WIDTH-1:0] phase_s_q;
            logic             w_wr;

            // Out-of-range indices match no channel and are dropped.
            assign w_wr = wr_en && (wr_ch == CHW'(c));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ton_s_q   <= '0;
                    phase_s_q <= '0;
                end else if (w_wr) begin
                    ton_s_q   <= wr_ton;
                    phase_s_q <= wr_phase;
                end
            end

            pwm_chan_cmp #(
                .WIDTH (WIDTH)
            ) u_cmp (
                .clk       (clk),
                .reset_n   (reset_n),
                .load_i    (w_xfer),
                .ton_s_i   (ton_s_q),
                .phase_s_i (phase_s_q),
                .cnt_i     (cnt_q),
                .period_i  (period_a_q),
                .oe_i      (oe[c]),
                .pwm_o     (pwm_out[c])
            );
        end
    endgenerate

    assign period_start   = period_start_q;
    assign update_pending = pending_q;
    assign update_done    = update_done_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_pwm_dbuf.sv
// ============================================================================
//  tb_multi_pwm_dbuf : self-checking bench for multi_pwm_dbuf (NCH=24, W=10)
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_multi_pwm_dbuf;

    localparam int NCH   = 24;
    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wr_en;
    logic [4:0]       wr_ch;
    logic [WIDTH-1:0] wr_ton;
    logic [WIDTH-1:0] wr_phase;
    logic             period_wr;
    logic [WIDTH-1:0] period_in;
    logic             commit;
    logic [NCH-1:0]   oe;
    logic [NCH-1:0]   pwm_out;
    logic             period_start;
    logic             update_pending;
    logic             update_done;

    always #5 clk = ~clk;

    multi_pwm_dbuf #(
        .NCH   (NCH),
        .WIDTH (WIDTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_ch          (wr_ch),
        .wr_ton         (wr_ton),
        .wr_phase       (wr_phase),
        .period_wr      (period_wr),
        .period_in      (period_in),
        .commit         (commit),
        .oe             (oe),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .update_pending (update_pending),
        .update_done    (update_done)
    );

    // pat bit k = expected output level at count k when the period is 10
    typedef struct {
        int         ch;
        int         ton;
        int         ph;
        logic [9:0] pat;
    } vec_t;

    typedef struct {
        logic [NCH-1:0] pwm;
        logic           ps;
        logic           pend;
        logic           done;
    } exp_t;

    vec_t       tbl [9];
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    int         m_cnt;
    int         m_p;
    int         m_ps_p;
    logic       m_pend;
    logic [9:0] pat_a [NCH];
    logic [9:0] pat_s [NCH];
    logic [9:0] wr_pat;

    task automatic check1(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_p    = 0;
        m_ps_p = 0;
        m_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            pat_a[i] = '0;
            pat_s[i] = '0;
        end
    endtask

    // One clock: predict outputs for the coming edge, push, advance, pop, compare.
    task automatic cyc();
        exp_t e;
        exp_t g;
        bit   xfer;
        for (int i = 0; i < NCH; i++) begin
            e.pwm[i] = (m_p != 0) && pat_a[i][m_cnt] && oe[i];
        end
        e.ps   = (m_p != 0) && (m_cnt == 0);
        xfer   = m_pend && ((m_p == 0) || (m_cnt == m_p - 1));
        e.done = xfer;
        e.pend = xfer ? 1'b0 : (m_pend | commit);
        sb.push_back(e);

        if (xfer) begin
            for (int i = 0; i < NCH; i++) pat_a[i] = pat_s[i];
            m_p   = m_ps_p;
            m_cnt = 0;
        end else if (m_p == 0) begin
            m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + 1) % m_p;
        end
        m_pend = e.pend;
        if (wr_en && (wr_ch < NCH)) pat_s[wr_ch] = wr_pat;
        if (period_wr) m_ps_p = int'(period_in);

        @(posedge clk);
        #1;
        g = sb.pop_front();
        check1("pwm_out",        pwm_out,             g.pwm);
        check1("period_start",   NCH'(period_start),   NCH'(g.ps));
        check1("update_pending", NCH'(update_pending), NCH'(g.pend));
        check1("update_done",    NCH'(update_done),    NCH'(g.done));
        wr_en     = 1'b0;
        period_wr = 1'b0;
        commit    = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int ch, input int ton, input int ph, input logic [9:0] pat);
        wr_en    = 1'b1;
        wr_ch    = 5'(ch);
        wr_ton   = 10'(ton);
        wr_phase = 10'(ph);
        wr_pat   = pat;
        cyc();
    endtask

    task automatic check_idle(input string tag);
        check1({tag, " pwm_out"},        pwm_out,             '0);
        check1({tag, " period_start"},   NCH'(period_start),   '0);
        check1({tag, " update_pending"}, NCH'(update_pending), '0);
        check1({tag, " update_done"},    NCH'(update_done),    '0);
    endtask

    initial begin
        tbl[0] = '{0,  3,    0,  10'h007};
        tbl[1] = '{1,  4,    8,  10'h303};
        tbl[2] = '{2,  4,    12, 10'h00F};
        tbl[3] = '{3,  0,    0,  10'h000};
        tbl[4] = '{4,  10,   0,  10'h3FF};
        tbl[5] = '{5,  1023, 3,  10'h3FF};
        tbl[6] = '{6,  5,    2,  10'h07C};
        tbl[7] = '{7,  9,    9,  10'h2FF};
        tbl[8] = '{23, 1,    9,  10'h200};

        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_ton    = '0;
        wr_phase  = '0;
        period_wr = 1'b0;
        period_in = '0;
        commit    = 1'b0;
        oe        = '1;
        wr_pat    = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;

        // Configure period 10 plus the channel table, then commit from stopped.
        period_wr = 1'b1;
        period_in = 10'd10;
        for (int r = 0; r < 9; r++) begin
            wr(tbl[r].ch, tbl[r].ton, tbl[r].ph, tbl[r].pat);
        end
        commit = 1'b1;
        cyc();
        run(25);

        // Output enable is unbuffered; out-of-range channel write is dropped.
        oe[5] = 1'b0;
        run(3);
        oe[5] = 1'b1;
        wr(30, 7, 0, 10'h3FF);
        run(2);

        // Mid-period update: commit at count 2, then write during the transfer.
        for (int i = 0; i < 12 && m_cnt != 1; i++) cyc();
        wr(0, 6, 0, 10'h03F);
        commit = 1'b1;
        cyc();
        for (int i = 0; i < 12 && m_cnt != 9; i++) cyc();
        wr(0, 8, 0, 10'h0FF);
        run(12);
        commit = 1'b1;
        cyc();
        run(22);

        // Period 0 stops everything.
        period_wr = 1'b1;
        period_in = '0;
        commit    = 1'b1;
        cyc();
        run(15);

        // Restart, set pending mid-period, then reset asynchronously.
        period_wr = 1'b1;
        period_in = 10'd10;
        commit    = 1'b1;
        cyc();
        run(5);
        commit = 1'b1;
        cyc();
        reset_n = 1'b0;
        #2;
        check_idle("async reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // A bare commit after reset must leave the block stopped.
        commit = 1'b1;
        cyc();
        run(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_pwm_dbuf.md
# multi_pwm_dbuf

Parametrised multi-channel PWM generator with a programmable period, per-channel duty and phase offset, and double-buffered (shadow/active) registers that swap only on a period boundary. It sits between the Nios PIO exports and the GPIO header and is clocked by the PLL-derived PWM clock. It generalises the fixed-width latch/Ton/OE scheme in three ways: independent duty per channel, glitch-free synchronous update of all channels, and a phase offset.

## Interface
- NCH, 24, number of PWM channels (1..64)
- WIDTH, 10, counter/duty/phase/period width in bits
- clk  in  1  PWM clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one channel's shadow duty and phase this cycle
- wr_ch  in  $clog2(NCH)  channel index; values ≥ NCH are ignored
- wr_ton  in  WIDTH  shadow high-time in counts
- wr_phase  in  WIDTH  shadow phase offset in counts
- period_wr  in  1  write shadow period
- period_in  in  WIDTH  shadow period in counts; 0 = stopped
- commit  in  1  single-cycle request to transfer all shadows to active
- oe  in  NCH  per-channel output enable; unbuffered
- pwm_out  out  NCH  registered PWM outputs
- period_start  out  1  pulse in the first cycle of each period
- update_pending  out  1  high from commit until the transfer is done
- update_done  out  1  one-cycle pulse when the transfer happens

## Operation
- Active set: period_a, ton_a[NCH], phase_a[NCH]. Shadow set: period_s, ton_s[NCH], phase_s[NCH]. wr_en and period_wr write only the shadow set.
- Running (period_a ≠ 0):
  - cnt counts 0..period_a−1 and then wraps to 0.
  - Boundary cycle: cnt == period_a−1.
- Stopped (period_a == 0): cnt is held at 0, all raw outputs are 0, and period_start stays 0.
- Raw output for channel i:
  - ph = phase_a[i] if phase_a[i] < period_a, else 0.
  - d = cnt − ph, with period_a added if the result is negative (WIDTH+1-bit arithmetic).
  - raw = (d < ton_a[i]).
  - Consequences: ton_a = 0 gives a constant 0; ton_a ≥ period_a gives a constant 1.
- pwm_out[i] = raw & oe[i], registered. oe low forces the output to 0 on the next edge.
- Commit:
  - commit sets pending.
  - At the end of a boundary cycle with pending set, all active registers load the shadow set, cnt goes to 0, pending clears, and update_done pulses in the first cycle of the new period.
  - When stopped, the transfer happens at the end of the cycle after pending is set.
- Simultaneous events:
  - wr_en and commit in the same cycle: the write is included in the transfer.
  - wr_en in the transfer cycle: the active set gets the old shadow value; the write stays in the shadow for the next commit.
  - commit in a boundary cycle: pending is set, but the transfer waits for the next boundary.
  - commit while already pending: no effect.
- Reset, mid-operation included: cnt = 0, all active and shadow registers = 0 (stopped), pending = 0, pwm_out = 0, period_start = 0, update_done = 0.

## Timing
- One output-register latency: pwm_out in cycle t reflects cnt and oe as sampled in cycle t−1.
- period_start is asserted in the same cycle as the output corresponding to cnt = 0.
- Transfer latency: at most period_a cycles after commit.
- Output period is exactly period_a clk cycles. High time per period is min(ton_a, period_a) cycles, starting at count ph.
- Newly committed values produce no runt or merged pulses: every period uses exactly one consistent active set.

## Structure
- Shared package multi_pwm_pkg holds:
  - default parameter constants
  - channel index width function (clog2)
  - typedef for a WIDTH-wide count
- Sub-module pwm_chan_cmp (one instance per channel, generate loop):
  - holds ton_a and phase_a
  - computes the phase-wrapped compare
  - registers its output bit
- Top holds the counter, the shadow registers, the pending/commit logic and the status pulses.

## Test plan
- Reset, then period_in = 10, ch0 ton = 3 / phase = 0, commit, oe = all-1 → update_done pulses after at most 1 cycle; pwm_out[0] is 3 high then 7 low, repeating; period_start every 10 cycles.
- ch1 ton = 4, phase = 8, P = 10 → ch1 is high at counts 8, 9, 0, 1, i.e. 4 cycles wrapping the boundary; phase = 12 behaves as phase 0.
- Running at P = 10: write ch0 ton = 6, commit at count 2 → old duty until the boundary, new duty from the next period_start, no runt pulse; a write during the transfer cycle does not appear until a second commit.
- Edge values: ton = 0 gives constant 0; ton = 10 and ton = 1023 give constant 1; period_in = 0 with commit gives all outputs 0 and no period_start.
- Drop oe[5] mid-pulse → pwm_out[5] = 0 on the next edge; other channels unaffected; wr_ch = 30 with NCH = 24 changes nothing.
- Assert reset_n low mid-period with pending set → all outputs and status signals 0 immediately; after release the block stays stopped until a new period write and commit.
